mand_iter: RTL and testbench

- Fixed-point Mandelbrot iteration core; sits directly downstream of the register/command block's trigger and upstream of its result FIFO.
- For each trigger it computes one step z(n+1) = z(n)^2 + c, plus an escape test on |z(n+1)|^2.
- Fully pipelined: accepts one trigger per clock with fixed latency.
- Passes c (x0, y0) through alongside the result so the FIFO entry is self-describing.

---
 rtl/mand_iter.sv | 129 ++++++++++++
 tb/tb_mand_iter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mand_iter.sv
// Fixed-point Mandelbrot step: z' = z^2 + c with an escape test on |z'|^2.
// Five registered stages, one trigger per clock, results appear four edges after the trigger.
module mand_iter #(
    parameter int FRAC = 28
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        trigger,
    input  logic [31:0] x0,
    input  logic [31:0] y0,
    input  logic [31:0] xn,
    input  logic [31:0] yn,
    output logic [31:0] xnext,
    output logic [31:0] ynext,
    output logic [31:0] x0next,
    output logic [31:0] y0next,
    output logic [31:0] result,
    output logic        complete,
    output logic [2:0]  inflight
);

    localparam logic [64:0] FOUR = 65'd4 << (2 * FRAC);

    // {saturated, value}: keep bits [FRAC+31:FRAC], clamp when the dropped top bits disagree
    function automatic logic [32:0] rescale(input logic [63:0] p);
        logic [32-FRAC:0] hi;
        hi = p[63:FRAC+31];
        if (hi == '0 || hi == '1) return {1'b0, p[FRAC+31:FRAC]};
        else if (p[63])           return {1'b1, 32'h8000_0000};
        else                      return {1'b1, 32'h7FFF_FFFF};
    endfunction

    function automatic logic [32:0] sat33(input logic [32:0] v);
        if (v[32] == v[31]) return {1'b0, v[31:0]};
        else if (v[32])     return {1'b1, 32'h8000_0000};
        else                return {1'b1, 32'h7FFF_FFFF};
    endfunction

    logic               s1_v_q, s2_v_q, s3_v_q, s4_v_q;
    logic        [31:0] s1_x0_q, s1_y0_q, s2_x0_q, s2_y0_q, s3_x0_q, s3_y0_q, s4_x0_q, s4_y0_q;
    logic signed [31:0] s1_xn_q, s1_yn_q;
    logic signed [63:0] s2_xx_q, s2_yy_q, s2_xy_q;
    logic signed [31:0] s3_xn1_q, s3_yn1_q;
    logic               s3_ovf_q, s4_ovf_q;
    logic        [63:0] s4_mx_q, s4_my_q;
    logic        [31:0] s4_xn1_q, s4_yn1_q;
    logic        [2:0]  inflight_q, inflight_d;

    logic signed [63:0] xx_d, yy_d, xy_d, mx_d, my_d;
    logic        [32:0] xx_r, yy_r, xy_r, dif_s, re_s, xy2_s, im_s;
    logic        [32:0] dif_w, re_w, im_w;
    logic        [31:0] xn1_d, yn1_d;
    logic               ovf_d;
    logic        [64:0] mag_d;
    logic               esc_d;

    always_comb begin
        xx_d = 64'(s1_xn_q) * 64'(s1_xn_q);
        yy_d = 64'(s1_yn_q) * 64'(s1_yn_q);
        xy_d = 64'(s1_xn_q) * 64'(s1_yn_q);
    end

    // Real and imaginary sums are each built from two 33-bit adds, saturating after each
    always_comb begin
        xx_r  = rescale(s2_xx_q);
        yy_r  = rescale(s2_yy_q);
        xy_r  = rescale(s2_xy_q);
        dif_w = {xx_r[31], xx_r[31:0]} - {yy_r[31], yy_r[31:0]};
        dif_s = sat33(dif_w);
        re_w  = {dif_s[31], dif_s[31:0]} + {s2_x0_q[31], s2_x0_q};
        re_s  = sat33(re_w);
        xy2_s = sat33({xy_r[31:0], 1'b0});
        im_w  = {xy2_s[31], xy2_s[31:0]} + {s2_y0_q[31], s2_y0_q};
        im_s  = sat33(im_w);
        xn1_d = re_s[31:0];
        yn1_d = im_s[31:0];
        ovf_d = xx_r[32] | yy_r[32] | xy_r[32] | dif_s[32] | re_s[32] | xy2_s[32] | im_s[32];
    end

    always_comb begin
        mx_d       = 64'(s3_xn1_q) * 64'(s3_xn1_q);
        my_d       = 64'(s3_yn1_q) * 64'(s3_yn1_q);
        mag_d      = {1'b0, s4_mx_q} + {1'b0, s4_my_q};
        esc_d      = (mag_d > FOUR) | s4_ovf_q;
        inflight_d = inflight_q + {2'b0, trigger} - {2'b0, complete};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_v_q <= 1'b0; s2_v_q <= 1'b0; s3_v_q <= 1'b0; s4_v_q <= 1'b0;
            s1_x0_q <= '0; s1_y0_q <= '0; s1_xn_q <= '0; s1_yn_q <= '0;
            s2_x0_q <= '0; s2_y0_q <= '0; s2_xx_q <= '0; s2_yy_q <= '0; s2_xy_q <= '0;
            s3_x0_q <= '0; s3_y0_q <= '0; s3_xn1_q <= '0; s3_yn1_q <= '0; s3_ovf_q <= 1'b0;
            s4_x0_q <= '0; s4_y0_q <= '0; s4_xn1_q <= '0; s4_yn1_q <= '0; s4_ovf_q <= 1'b0;
            s4_mx_q <= '0; s4_my_q <= '0;
            xnext <= '0; ynext <= '0; x0next <= '0; y0next <= '0; result <= '0;
            complete   <= 1'b0;
            inflight_q <= '0;
        end else begin
            s1_v_q <= trigger;
            if (trigger) begin
                s1_x0_q <= x0; s1_y0_q <= y0; s1_xn_q <= xn; s1_yn_q <= yn;
            end
            s2_v_q  <= s1_v_q;
            s2_x0_q <= s1_x0_q; s2_y0_q <= s1_y0_q;
            s2_xx_q <= xx_d; s2_yy_q <= yy_d; s2_xy_q <= xy_d;
            s3_v_q   <= s2_v_q;
            s3_x0_q  <= s2_x0_q; s3_y0_q <= s2_y0_q;
            s3_xn1_q <= xn1_d; s3_yn1_q <= yn1_d; s3_ovf_q <= ovf_d;
            s4_v_q   <= s3_v_q;
            s4_x0_q  <= s3_x0_q; s4_y0_q <= s3_y0_q;
            s4_xn1_q <= s3_xn1_q; s4_yn1_q <= s3_yn1_q; s4_ovf_q <= s3_ovf_q;
            s4_mx_q  <= mx_d; s4_my_q <= my_d;
            complete <= s4_v_q;
            // Output registers hold the last completed result between completions
            if (s4_v_q) begin
                xnext  <= s4_xn1_q;
                ynext  <= s4_yn1_q;
                x0next <= s4_x0_q;
                y0next <= s4_y0_q;
                result <= {30'b0, s4_ovf_q, esc_d};
            end
            inflight_q <= inflight_d;
        end
    end

    assign inflight = inflight_q;

endmodule

// File: tb/tb_mand_iter.sv
// Directed bench for mand_iter (FRAC = 28, 1.0 = 0x10000000) with hand-computed expectations.
module tb_mand_iter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        trigger;
    logic [31:0] x0, y0, xn, yn;
    logic [31:0] xnext, ynext, x0next, y0next, result;
    logic        complete;
    logic [2:0]  inflight;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    mand_iter #(.FRAC(28)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .trigger  (trigger),
        .x0       (x0),
        .y0       (y0),
        .xn       (xn),
        .yn       (yn),
        .xnext    (xnext),
        .ynext    (ynext),
        .x0next   (x0next),
        .y0next   (y0next),
        .result   (result),
        .complete (complete),
        .inflight (inflight)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic t, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
        trigger = t; xn = a; yn = b; x0 = c; y0 = d;
    endtask

    task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d,
                          input logic [31:0] ex, input logic [31:0] ey, input logic [31:0] er);
        drive(1'b1, a, b, c, d);
        tick();
        drive(1'b0, '0, '0, '0, '0);
        repeat (3) begin
            tick();
            chk({tag, "_nocomplete"}, {31'b0, complete}, 32'd0);
        end
        tick();
        chk({tag, "_complete"}, {31'b0, complete}, 32'd1);
        chk({tag, "_xnext"},    xnext,  ex);
        chk({tag, "_ynext"},    ynext,  ey);
        chk({tag, "_result"},   result, er);
        chk({tag, "_x0next"},   x0next, c);
        chk({tag, "_y0next"},   y0next, d);
        tick();
        chk({tag, "_pulse"},    {31'b0, complete}, 32'd0);
        chk({tag, "_hold"},     xnext, ex);
        chk({tag, "_inflight"}, {29'b0, inflight}, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        drive(1'b0, '0, '0, '0, '0);
        repeat (2) tick();
        rst_i = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_complete", {31'b0, complete}, 32'd0);
            chk("idle_inflight", {29'b0, inflight}, 32'd0);
        end
        chk("idle_xnext",  xnext,  32'd0);
        chk("idle_ynext",  ynext,  32'd0);
        chk("idle_x0next", x0next, 32'd0);
        chk("idle_y0next", y0next, 32'd0);
        chk("idle_result", result, 32'd0);

        // Zero operation: latency 4 and inflight pulse
        drive(1'b1, '0, '0, '0, '0);
        tick();
        chk("zero_inflight_e0", {29'b0, inflight}, 32'd1);
        drive(1'b0, '0, '0, '0, '0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("zero_nocomplete", {31'b0, complete}, 32'd0);
            chk("zero_inflight",   {29'b0, inflight}, 32'd1);
        end
        tick();
        chk("zero_complete",    {31'b0, complete}, 32'd1);
        chk("zero_inflight_e4", {29'b0, inflight}, 32'd1);
        chk("zero_xnext",  xnext,  32'd0);
        chk("zero_ynext",  ynext,  32'd0);
        chk("zero_result", result, 32'd0);
        tick();
        chk("zero_pulse",       {31'b0, complete}, 32'd0);
        chk("zero_inflight_e5", {29'b0, inflight}, 32'd0);

        // |z'|^2 exactly 4.0 is not escaped
        single("four", 32'h1000_0000, 32'h0, 32'h1000_0000, 32'h0,
               32'h2000_0000, 32'h0, 32'd0);
        // z = 1+i, c = 1/16: escaped without overflow
        single("esc", 32'h1000_0000, 32'h1000_0000, 32'h0100_0000, 32'h0,
               32'h0100_0000, 32'h2000_0000, 32'd1);
        // 7.0^2 saturates
        single("ovf", 32'h7000_0000, 32'h0, 32'h0, 32'h0,
               32'h7FFF_FFFF, 32'h0, 32'd3);

        // Back-to-back three operations
        drive(1'b1, 32'h1000_0000, 32'h0, 32'h1000_0000, 32'h0);
        tick();
        drive(1'b1, 32'h1000_0000, 32'h1000_0000, 32'h0100_0000, 32'h0);
        tick();
        chk("b2b_inflight_e1", {29'b0, inflight}, 32'd2);
        drive(1'b1, 32'h7000_0000, 32'h0, 32'h0, 32'h0);
        tick();
        chk("b2b_inflight_e2", {29'b0, inflight}, 32'd3);
        drive(1'b0, '0, '0, '0, '0);
        tick();
        chk("b2b_nocomplete_e3", {31'b0, complete}, 32'd0);
        chk("b2b_inflight_e3",   {29'b0, inflight}, 32'd3);
        tick();
        chk("b2b_a_complete", {31'b0, complete}, 32'd1);
        chk("b2b_a_xnext",    xnext,  32'h2000_0000);
        chk("b2b_a_result",   result, 32'd0);
        chk("b2b_a_x0next",   x0next, 32'h1000_0000);
        chk("b2b_inflight_e4", {29'b0, inflight}, 32'd3);
        tick();
        chk("b2b_b_complete", {31'b0, complete}, 32'd1);
        chk("b2b_b_xnext",    xnext,  32'h0100_0000);
        chk("b2b_b_ynext",    ynext,  32'h2000_0000);
        chk("b2b_b_result",   result, 32'd1);
        chk("b2b_b_x0next",   x0next, 32'h0100_0000);
        chk("b2b_inflight_e5", {29'b0, inflight}, 32'd2);
        tick();
        chk("b2b_c_complete", {31'b0, complete}, 32'd1);
        chk("b2b_c_xnext",    xnext,  32'h7FFF_FFFF);
        chk("b2b_c_ynext",    ynext,  32'h0);
        chk("b2b_c_result",   result, 32'd3);
        chk("b2b_inflight_e6", {29'b0, inflight}, 32'd1);
        tick();
        chk("b2b_end_complete", {31'b0, complete}, 32'd0);
        chk("b2b_end_inflight", {29'b0, inflight}, 32'd0);

        // Asynchronous reset discards in-flight work
        drive(1'b1, 32'h1000_0000, 32'h0, 32'h1000_0000, 32'h0);
        tick();
        drive(1'b1, 32'h7000_0000, 32'h0, 32'h0, 32'h0);
        tick();
        drive(1'b0, '0, '0, '0, '0);
        tick();
        #2 rst_i = 1'b1;
        #1;
        chk("rst_xnext",    xnext,  32'd0);
        chk("rst_result",   result, 32'd0);
        chk("rst_complete", {31'b0, complete}, 32'd0);
        chk("rst_inflight", {29'b0, inflight}, 32'd0);
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst_after_complete", {31'b0, complete}, 32'd0);
            chk("rst_after_inflight", {29'b0, inflight}, 32'd0);
        end
        chk("rst_after_xnext", xnext, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
